core_sequencer: RTL

Multi-cycle control sequencer for the RV32 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the instruction- and data-memory request/acknowledge handshakes and issues the per-state datapath strobes (IR/PC/register-file writes, ALU source and op, memory direction). Illegal opcodes and memory-handshake timeouts put the core in a sticky trap state. The block sits between the instruction register/decoder and the shared datapath, and it is the only source of write enables in the core.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/seq_watchdog.sv | 35 +++
 rtl/core_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the RV32 multi-cycle sequencer.
// Includes the opcode constants, the FSM states, the instruction classes and the trap causes.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_IALU    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } class_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_IALU:   return CLS_IALU;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-handshake watchdog: counts wait cycles since the last clear and flags expiry.
// An ack in the expiry cycle masks the flag, so a late-but-in-time ack always wins.
module seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expired
);

  localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST    = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          ENABLED = (TIMEOUT != 0);

  logic [CW-1:0] r_cnt;

  // r_cnt == LAST means this is wait cycle number TIMEOUT; saturate there
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = ENABLED && enable && !ack && (r_cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with a sticky trap state.
// Strobes are decoded from the registered state, and every output is forced to 0 while rst_n is low.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [1:0]       aluop,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  state_t           r_state, w_next;
  class_t           r_class;
  logic [CNT_W-1:0] r_retired;
  logic             r_trap;
  logic [1:0]       r_cause, w_cause;
  logic             w_expired, w_wait, w_ack;
  logic             w_imem_req, w_dmem_req, w_dmem_we, w_ir_write, w_pc_write;
  logic             w_pc_src, w_reg_write, w_alu_src, w_mem_to_reg;
  aluop_t           w_aluop;

  assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMORY);
  assign w_ack  = (r_state == S_FETCH) ? imem_ack : dmem_ack;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_next != r_state),
    .enable  (w_wait),
    .ack     (w_ack),
    .expired (w_expired)
  );

  // Next state and per-state strobes
  always_comb begin
    w_next       = r_state;
    w_cause      = r_cause;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_aluop      = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_IMEM;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (decode_class(opcode) == CLS_ILLEGAL) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_ILLEGAL;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (r_class)
          CLS_R: begin
            w_aluop = ALU_FUNCT;
            w_next  = S_WRITEBACK;
          end
          CLS_IALU: begin
            w_alu_src = 1'b1;
            w_next    = S_WRITEBACK;
          end
          CLS_LOAD, CLS_STORE: begin
            w_alu_src = 1'b1;
            w_next    = S_MEMORY;
          end
          CLS_BRANCH: begin
            w_aluop    = ALU_SUB;
            w_pc_write = 1'b1;
            w_pc_src   = alu_zero;
            w_next     = S_FETCH;
          end
          default: begin
            w_next  = S_TRAP;
            w_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMORY: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_class == CLS_STORE);
        if (dmem_ack) begin
          if (r_class == CLS_STORE) begin
            w_pc_write = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WRITEBACK;
          end
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_DMEM;
        end else begin
          w_next = S_MEMORY;
        end
      end
      S_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (r_class == CLS_LOAD);
        w_pc_write   = 1'b1;
        w_next       = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State, class latch, retire counter and sticky trap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_class   <= CLS_R;
      r_retired <= '0;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= decode_class(opcode);
      end
      if (w_pc_write) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
    end
  end

  assign imem_req   = rst_n & w_imem_req;
  assign dmem_req   = rst_n & w_dmem_req;
  assign dmem_we    = rst_n & w_dmem_we;
  assign ir_write   = rst_n & w_ir_write;
  assign pc_write   = rst_n & w_pc_write;
  assign pc_src     = rst_n & w_pc_src;
  assign reg_write  = rst_n & w_reg_write;
  assign alu_src    = rst_n & w_alu_src;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign aluop      = rst_n ? w_aluop : 2'b00;
  assign retired    = rst_n ? r_retired : '0;
  assign trap       = rst_n & r_trap;
  assign trap_cause = rst_n ? r_cause : 2'b00;

endmodule
